lutram_march_ctrl: RTL and testbench
====================================

Name: lutram_march_ctrl

Overview:
- Built-in self-test sequencer for one single-port, 1-bit-wide LUTRAM primitive such as RAM256X1S: synchronous write, asynchronous read.
- Drives the RAM's address, data and write-enable, and runs the March C- algorithm over all 2^AW locations.
- Compares the read data against expected values and reports pass/fail.
- Sits between the board-level test harness (start/status pins) and the LUTRAM under test; everything runs on one clock domain.

Parameters:
- AW, 8, RAM address width; depth N = 2^AW.
- STOP_ON_FAIL, 0, 1 = abort to DONE on the first mismatch; 0 = run the full algorithm.

Ports:
- clk  in  1  RAM write clock and controller clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a test; sampled only in IDLE or DONE
- busy  out  1  high while a march element is executing
- done  out  1  high while in DONE
- pass  out  1  done & ~fail
- fail  out  1  sticky mismatch flag; cleared on start
- ram_addr  out  AW  to RAM A
- ram_d  out  1  to RAM D
- ram_we  out  1  to RAM WE
- ram_q  in  1  from RAM O (asynchronous read)

Behaviour:
- Reset values: state=IDLE, ram_addr=0, fail=0. Outputs: busy=0, done=0, pass=0, ram_we=0, ram_d=0.
- States: IDLE, M0, M1, M2, M3, M4, M5, DONE (3-bit encoding).
- Elements:
  - M0 up, w0
  - M1 up, r0 w1
  - M2 up, r1 w0
  - M3 down, r0 w1
  - M4 down, r1 w0
  - M5 up, r0
- Each element takes one cycle per address.
  - In a read-write element, ram_q is compared combinationally in the same cycle that ram_we=1 and ram_d=new value.
  - The asynchronous read returns the old content; the write commits at the clock edge.
- ram_we = 1 in M0..M4, 0 otherwise. ram_d = write value of the current element; 0 when ram_we=0.
- Compare enable = state in M1..M5. A mismatch is ram_q != expected value (M1/M3/M5 expect 0, M2/M4 expect 1). A mismatch sets fail at the next edge.
- Address generation:
  - Up elements count 0..N-1; down elements count N-1..0.
  - At the terminal address the state advances and ram_addr loads the next element's start address: 0 for M1, M2, M5; N-1 for M3, M4.
- IDLE/DONE with start=1: next state M0, ram_addr=0, fail cleared.
- start is ignored while busy.
- M5 at its terminal address: next state DONE. DONE holds until start or rst.
- Total busy duration = 6N cycles (1536 for AW=8).
- STOP_ON_FAIL=1: a mismatch cycle goes directly to DONE at the next edge. The write in that cycle still occurs.
- rst mid-run: at the next edge everything returns to reset values and ram_we drops. RAM contents are left undefined.
- Address arithmetic is AW bits, wrap-free: terminal detection prevents overflow.

Optional Feature:
- Macro: LUTRAM_MARCH_FAIL_LOG_EN.
- Defined: adds outputs fail_addr[AW-1:0], fail_elem[2:0] and err_cnt[15:0].
  - fail_addr and fail_elem capture the address and element of the first mismatch only.
  - err_cnt counts every mismatch and saturates at 0xFFFF.
  - All three reset to 0 and clear on start.
- Undefined: these ports and registers are absent; only the fail flag is reported.

Decomposition:
- Package lutram_march_pkg holds:
  - state encodings;
  - per-element tables: direction, write-enable, write value, compare-enable, expected value;
  - N derived from AW.
- One sub-module, lutram_march_addr_gen:
  - AW-bit up/down counter with load value, direction and terminal flag;
  - instantiated once.

Test Plan:
- Fault-free behavioural 256x1 model, AW=8, one-cycle start → busy=1 from the next cycle for exactly 1536 cycles, then done=1, pass=1, fail=0.
- Stuck-at-1 at 0x5A → fail=1, pass=0. With the macro: fail_addr=0x5A, fail_elem=1, err_cnt=3 (mismatches in M1, M3, M5).
- Stuck-at-0 at 0x00 → first mismatch in M2 at address 0x00. With the macro: fail_elem=2, err_cnt=2.
- STOP_ON_FAIL=1, stuck-at-1 at 0x10 → mismatch on busy cycle 273 (256 + 17), then done=1 with exactly 273 busy cycles.
- rst asserted during busy cycle 700 → next cycle busy=0, ram_we=0, done=0, fail=0. A following start completes the fault-free run in 1536 cycles.
- start pulsed mid-run → no effect. start in DONE after a failing run → fail cleared, test reruns.

Source files
------------

// File: rtl/lutram_march_pkg.sv
// -----------------------------------------------------------------------------
// lutram_march_pkg
// Shared definitions for the LUTRAM March C- self-test sequencer:
//   - march_state_e : 3-bit controller state encoding
//   - elem_cfg_t    : per-element behaviour (direction, write, compare)
//   - elem_cfg()    : element table lookup by state
//   - next_elem()   : element ordering M0 -> M1 -> ... -> M5 -> DONE
//   - elem_index()  : element number reported in the failure log
//   - depth()       : RAM depth N = 2^AW
// No ports (package).
// -----------------------------------------------------------------------------
package lutram_march_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_M4   = 3'd5,
    ST_M5   = 3'd6,
    ST_DONE = 3'd7
  } march_state_e;

  typedef struct packed {
    logic up;   // address direction: 1 = 0..N-1, 0 = N-1..0
    logic we;   // element writes every address
    logic wd;   // value written
    logic cmp;  // element reads and compares every address
    logic exp;  // value expected on the read
  } elem_cfg_t;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // March C-: {up w0} {up r0 w1} {up r1 w0} {dn r0 w1} {dn r1 w0} {up r0}
  function automatic elem_cfg_t elem_cfg(input march_state_e s);
    elem_cfg_t c;
    c = '{up: 1'b1, we: 1'b0, wd: 1'b0, cmp: 1'b0, exp: 1'b0};
    case (s)
      ST_M0: c = '{up: 1'b1, we: 1'b1, wd: 1'b0, cmp: 1'b0, exp: 1'b0};
      ST_M1: c = '{up: 1'b1, we: 1'b1, wd: 1'b1, cmp: 1'b1, exp: 1'b0};
      ST_M2: c = '{up: 1'b1, we: 1'b1, wd: 1'b0, cmp: 1'b1, exp: 1'b1};
      ST_M3: c = '{up: 1'b0, we: 1'b1, wd: 1'b1, cmp: 1'b1, exp: 1'b0};
      ST_M4: c = '{up: 1'b0, we: 1'b1, wd: 1'b0, cmp: 1'b1, exp: 1'b1};
      ST_M5: c = '{up: 1'b1, we: 1'b0, wd: 1'b0, cmp: 1'b1, exp: 1'b0};
      default: c = '{up: 1'b1, we: 1'b0, wd: 1'b0, cmp: 1'b0, exp: 1'b0};
    endcase
    return c;
  endfunction

  function automatic march_state_e next_elem(input march_state_e s);
    march_state_e n;
    case (s)
      ST_M0:   n = ST_M1;
      ST_M1:   n = ST_M2;
      ST_M2:   n = ST_M3;
      ST_M3:   n = ST_M4;
      ST_M4:   n = ST_M5;
      ST_M5:   n = ST_DONE;
      default: n = s;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] elem_index(input march_state_e s);
    logic [2:0] i;
    case (s)
      ST_M1:   i = 3'd1;
      ST_M2:   i = 3'd2;
      ST_M3:   i = 3'd3;
      ST_M4:   i = 3'd4;
      ST_M5:   i = 3'd5;
      default: i = 3'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/lutram_march_addr_gen.sv
// -----------------------------------------------------------------------------
// lutram_march_addr_gen
// AW-bit up/down address counter for the march sequencer.
// Ports:
//   clk, rst        clock, synchronous active-high reset (addr -> 0)
//   load, load_val  load a start address (takes priority over counting)
//   en, up          step the address by one in the given direction
//   addr            current RAM address
//   last            current address is the terminal one for direction 'up'
// -----------------------------------------------------------------------------
module lutram_march_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  output logic [AW-1:0] addr,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (en) begin
      addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
  end

  // The controller always loads at the terminal address, so the counter
  // never wraps.
  assign last = up ? (addr == {AW{1'b1}}) : (addr == {AW{1'b0}});

endmodule

// File: rtl/lutram_march_ctrl.sv
// -----------------------------------------------------------------------------
// lutram_march_ctrl
// March C- built-in self-test sequencer for a single-port 1-bit LUTRAM with
// synchronous write and asynchronous read. One cycle per address per element;
// in read-write elements the old content is compared in the same cycle the
// new value is written.
// Parameters:
//   AW            RAM address width (depth 2^AW)
//   STOP_ON_FAIL  1 = abort to DONE on the first mismatch
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a test (honoured only in IDLE or DONE)
//   busy, done    running a march element / finished
//   pass, fail    result (fail is sticky, cleared on start)
//   ram_addr, ram_d, ram_we, ram_q   LUTRAM interface
// Optional (macro LUTRAM_MARCH_FAIL_LOG_EN):
//   fail_addr, fail_elem  address/element of the first mismatch
//   err_cnt               saturating count of all mismatches
//
// state   | meaning
// IDLE    | waiting for start after reset
// M0      | up,   w0
// M1      | up,   r0 w1
// M2      | up,   r1 w0
// M3      | down, r0 w1
// M4      | down, r1 w0
// M5      | up,   r0
// DONE    | result valid, waiting for start
// -----------------------------------------------------------------------------
module lutram_march_ctrl
  import lutram_march_pkg::*;
#(
  parameter int AW           = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [AW-1:0] ram_addr,
  output logic          ram_d,
  output logic          ram_we,
  input  logic          ram_q
`ifdef LUTRAM_MARCH_FAIL_LOG_EN
  ,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [15:0]   err_cnt
`endif
);

  localparam int unsigned   N        = depth(AW);
  localparam logic [AW-1:0] ADDR_MAX = AW'(N - 1);

  march_state_e  state_q, state_d;
  elem_cfg_t     cfg;
  logic          in_elem;
  logic          launch;
  logic          mismatch;
  logic          ag_load;
  logic [AW-1:0] ag_load_val;
  logic          ag_last;

  assign cfg      = elem_cfg(state_q);
  assign in_elem  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign launch   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign mismatch = cfg.cmp && (ram_q != cfg.exp);

  lutram_march_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .en       (in_elem),
    .up       (cfg.up),
    .addr     (ram_addr),
    .last     (ag_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and address load. The start address of the following element
  // comes from its direction: up elements start at 0, down elements at N-1.
  always_comb begin
    state_d     = state_q;
    ag_load     = 1'b0;
    ag_load_val = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_M0;
          ag_load = 1'b1;
        end
      end
      default: begin
        if (STOP_ON_FAIL && mismatch) begin
          state_d = ST_DONE;
          ag_load = 1'b1;
        end else if (ag_last) begin
          state_d     = next_elem(state_q);
          ag_load     = 1'b1;
          ag_load_val = elem_cfg(state_d).up ? '0 : ADDR_MAX;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy   = in_elem;
    done   = (state_q == ST_DONE);
    pass   = (state_q == ST_DONE) && !fail;
    ram_we = cfg.we;
    ram_d  = cfg.we && cfg.wd;
  end

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      fail <= 1'b0;
    end else if (mismatch) begin
      fail <= 1'b1;
    end
  end

`ifdef LUTRAM_MARCH_FAIL_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      fail_addr <= '0;
      fail_elem <= 3'd0;
      err_cnt   <= 16'd0;
    end else if (mismatch) begin
      // fail is still low on the first mismatch of a run
      if (!fail) begin
        fail_addr <= ram_addr;
        fail_elem <= elem_index(state_q);
      end
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lutram_march_ctrl.sv
`timescale 1ns/1ps
module tb_lutram_march_ctrl;

  localparam int AW = 8;
  localparam int N  = 256;

  // March C- as written in the algorithm description, element by element
  localparam int EL_UP  [6] = '{1, 1, 1, 0, 0, 1};
  localparam int EL_RD  [6] = '{0, 1, 1, 1, 1, 1};
  localparam int EL_EXP [6] = '{0, 0, 1, 0, 1, 0};
  localparam int EL_WR  [6] = '{1, 1, 1, 1, 1, 0};
  localparam int EL_WV  [6] = '{0, 1, 0, 1, 0, 0};

  typedef struct {
    int cycles;
    bit fail;
    int fa;
    int fe;
    int ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start;

  // dut0: full run; dut1: STOP_ON_FAIL
  logic          busy0, done0, pass0, fail0, d0, we0, q0;
  logic [AW-1:0] a0;
  logic          busy1, done1, pass1, fail1, d1, we1, q1;
  logic [AW-1:0] a1;
`ifdef LUTRAM_MARCH_FAIL_LOG_EN
  logic [AW-1:0] fa0, fa1;
  logic [2:0]    fe0, fe1;
  logic [15:0]   ec0, ec1;
`endif

  bit mem0 [N];
  bit mem1 [N];
  bit fen  [2];
  int fad  [2];
  bit fv   [2];

  exp_t q_exp0[$];
  exp_t q_exp1[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lutram_march_ctrl #(.AW(AW), .STOP_ON_FAIL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .pass(pass0), .fail(fail0), .ram_addr(a0), .ram_d(d0), .ram_we(we0),
    .ram_q(q0)
`ifdef LUTRAM_MARCH_FAIL_LOG_EN
    , .fail_addr(fa0), .fail_elem(fe0), .err_cnt(ec0)
`endif
  );

  lutram_march_ctrl #(.AW(AW), .STOP_ON_FAIL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .pass(pass1), .fail(fail1), .ram_addr(a1), .ram_d(d1), .ram_we(we1),
    .ram_q(q1)
`ifdef LUTRAM_MARCH_FAIL_LOG_EN
    , .fail_addr(fa1), .fail_elem(fe1), .err_cnt(ec1)
`endif
  );

  // 256x1 LUTRAMs: synchronous write, asynchronous read, optional stuck-at cell
  always @(posedge clk) begin
    if (we0) mem0[a0] <= d0;
    if (we1) mem1[a1] <= d1;
  end
  always_comb begin
    q0 = (fen[0] && int'(a0) == fad[0]) ? fv[0] : mem0[a0];
    q1 = (fen[1] && int'(a1) == fad[1]) ? fv[1] : mem1[a1];
  end

  // Reference: walk March C- over an array, one busy cycle per address visit
  function automatic exp_t model(bit fe_on, int f_addr, bit f_val, bit sof);
    exp_t e;
    bit   m [N];
    bit   stopped;
    int   a;
    bit   rd;
    e.cycles = 0; e.fail = 0; e.fa = 0; e.fe = 0; e.ec = 0;
    stopped = 0;
    for (int el = 0; el < 6 && !stopped; el++) begin
      for (int k = 0; k < N && !stopped; k++) begin
        a  = (EL_UP[el] != 0) ? k : N - 1 - k;
        rd = (fe_on && a == f_addr) ? f_val : m[a];
        e.cycles++;
        if (EL_RD[el] != 0 && int'(rd) != EL_EXP[el]) begin
          if (!e.fail) begin
            e.fa = a;
            e.fe = el;
          end
          e.fail = 1;
          if (e.ec < 65535) e.ec++;
          if (sof) stopped = 1;
        end
        if (EL_WR[el] != 0) m[a] = (EL_WV[el] != 0);
      end
    end
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic score(int id, int cyc, bit f, bit p, int fa, int fe, int ec);
    exp_t e;
    if ((id == 0 && q_exp0.size() == 0) || (id == 1 && q_exp1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL dut%0d unexpected_done: got done, expected no run", id);
      return;
    end
    e = (id == 0) ? q_exp0.pop_front() : q_exp1.pop_front();
    check($sformatf("dut%0d busy_cycles", id), cyc, e.cycles);
    check($sformatf("dut%0d fail", id), int'(f), int'(e.fail));
    check($sformatf("dut%0d pass", id), int'(p), int'(!e.fail));
`ifdef LUTRAM_MARCH_FAIL_LOG_EN
    check($sformatf("dut%0d fail_addr", id), fa, e.fa);
    check($sformatf("dut%0d fail_elem", id), fe, e.fe);
    check($sformatf("dut%0d err_cnt", id), ec, e.ec);
`else
    if (fa != 0 || fe != 0 || ec != 0) $display("note: log fields ignored");
`endif
  endtask

  // Monitor: counts busy cycles and scores each run when done rises out of busy
  initial begin
    int cnt0, cnt1;
    bit pb0, pb1;
    int xa0, xe0, xc0, xa1, xe1, xc1;
    cnt0 = 0; cnt1 = 0; pb0 = 0; pb1 = 0;
    forever begin
      @(negedge clk);
`ifdef LUTRAM_MARCH_FAIL_LOG_EN
      xa0 = int'(fa0); xe0 = int'(fe0); xc0 = int'(ec0);
      xa1 = int'(fa1); xe1 = int'(fe1); xc1 = int'(ec1);
`else
      xa0 = 0; xe0 = 0; xc0 = 0; xa1 = 0; xe1 = 0; xc1 = 0;
`endif
      if (busy0 === 1'b1) cnt0++;
      else begin
        if (done0 === 1'b1 && pb0) score(0, cnt0, fail0, pass0, xa0, xe0, xc0);
        cnt0 = 0;
      end
      if (busy1 === 1'b1) cnt1++;
      else begin
        if (done1 === 1'b1 && pb1) score(1, cnt1, fail1, pass1, xa1, xe1, xc1);
        cnt1 = 0;
      end
      pb0 = (busy0 === 1'b1);
      pb1 = (busy1 === 1'b1);
    end
  end

  task automatic set_faults(bit e0, int ad0, bit v0, bit e1, int ad1, bit v1);
    fen[0] = e0; fad[0] = ad0; fv[0] = v0;
    fen[1] = e1; fad[1] = ad1; fv[1] = v1;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("busy0 first_cycle", int'(busy0), 1);
    check("busy1 first_cycle", int'(busy1), 1);
    check("fail0 cleared_on_start", int'(fail0), 0);
    check("fail1 cleared_on_start", int'(fail1), 0);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 2000 && !(done0 === 1'b1 && done1 === 1'b1); i++) @(negedge clk);
    if (!(done0 === 1'b1 && done1 === 1'b1)) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: got done0=%0b done1=%0b, expected both done", done0, done1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_test(bit e0, int ad0, bit v0, bit e1, int ad1, bit v1, bit mid_pulse);
    set_faults(e0, ad0, v0, e1, ad1, v1);
    q_exp0.push_back(model(e0, ad0, v0, 1'b0));
    q_exp1.push_back(model(e1, ad1, v1, 1'b1));
    pulse_start();
    if (mid_pulse) begin
      repeat (300) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_faults(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst busy", int'(busy0), 0);
    check("rst done", int'(done0), 0);
    check("rst pass", int'(pass0), 0);
    check("rst fail", int'(fail0), 0);
    check("rst ram_we", int'(we0), 0);
    check("rst ram_d", int'(d0), 0);
    check("rst ram_addr", int'(a0), 0);
    check("rst busy1", int'(busy1), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle busy", int'(busy0), 0);
    check("idle done", int'(done0), 0);

    // fault-free, with a start pulse mid-run that must be ignored
    run_test(0, 0, 0, 0, 0, 0, 1'b1);
    // stuck-at-1 at 0x5A (full run) and at 0x10 (stop on fail)
    run_test(1, 8'h5A, 1, 1, 8'h10, 1, 1'b0);
    // restart from a failing DONE: stuck-at-0 at 0x00 on both
    run_test(1, 8'h00, 0, 1, 8'h00, 0, 1'b0);

    // reset during busy cycle 700 of a run already failing
    set_faults(1, 8'h05, 1, 0, 0, 0);
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (699) @(negedge clk);
    check("pre_rst fail0", int'(fail0), 1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst busy0", int'(busy0), 0);
    check("mid_rst ram_we0", int'(we0), 0);
    check("mid_rst done0", int'(done0), 0);
    check("mid_rst fail0", int'(fail0), 0);
    check("mid_rst busy1", int'(busy1), 0);
    check("mid_rst ram_we1", int'(we1), 0);
    #1 rst = 1'b0;
    run_test(0, 0, 0, 0, 0, 0, 1'b0);

    // randomized single stuck-at faults
    for (int r = 0; r < 4; r++) begin
      run_test(1'($urandom % 2), int'($urandom_range(0, N - 1)), 1'($urandom % 2),
               1'($urandom % 2), int'($urandom_range(0, N - 1)), 1'($urandom % 2), 1'b0);
    end

    check("dut0 pending_runs", q_exp0.size(), 0);
    check("dut1 pending_runs", q_exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
